htif_loader: RTL

Host-target loader sitting directly upstream of the scratchpad memory's data port. It accepts a byte-serial command stream from the host, assembles little-endian 32-bit words, and issues full-word write requests on a dmem-style request port. It holds the core in reset until the host sends GO. After GO, top-level muxing hands the dmem port to the core.

---
 rtl/htif_loader_pkg.sv | 21 ++
 rtl/htif_loader.sv | 105 ++++++++++
 2 files changed

// File: rtl/htif_loader_pkg.sv
// Shared types and constants for the host-target loader.
// Command bytes, loader FSM states and the fixed dmem request encoding.
package htif_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    WRITE,
    RUN,
    ERR
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_GO    = 8'h02;

  localparam logic       M_XWR = 1'b1;
  localparam logic [2:0] MT_W  = 3'd3;

endpackage

// File: rtl/htif_loader.sv
// Byte-serial host loader: assembles little-endian address/count/data words
// and issues full-word dmem writes, then releases the core on GO.
module htif_loader
  import htif_loader_pkg::*;
#(
  parameter int AW = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [7:0]    host_data,
  input  logic          mem_req_ready,
  output logic          mem_req_valid,
  output logic [AW-1:0] mem_req_addr,
  output logic [31:0]   mem_req_data,
  output logic          mem_req_fcn,
  output logic [2:0]    mem_req_typ,
  output logic          core_run,
  output logic          err,
  output logic [LW-1:0] words_written
);

  state_e        state, state_nx;
  logic [1:0]    idx;
  logic [31:0]   word_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] remain_q;
  logic [LW-1:0] ww_q;

  logic          receiving;
  logic          xfer;
  logic          last_byte;
  logic          write_done;
  logic [31:0]   asm_word;
  logic [LW-1:0] len_val;

  assign receiving  = (state == IDLE) || (state == ADDR) || (state == LEN) || (state == DATA);
  assign xfer       = host_valid & receiving;
  // LEN carries two bytes; ADDR and DATA carry four.
  assign last_byte  = (state == LEN) ? (idx == 2'd1) : (idx == 2'd3);
  assign write_done = (state == WRITE) & mem_req_ready;
  assign asm_word   = {host_data, word_q[31:8]};
  assign len_val    = LW'({host_data, word_q[31:24]});

  // NOTE: every flop is written with <= so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: assigning the default first guarantees no path through the case infers a latch.
    state_nx = state;
    unique case (state)
      IDLE: if (xfer) begin
        if (host_data == CMD_WRITE)   state_nx = ADDR;
        else if (host_data == CMD_GO) state_nx = RUN;
        else                          state_nx = ERR;
      end
      ADDR:  if (xfer && last_byte) state_nx = LEN;
      LEN:   if (xfer && last_byte) state_nx = (len_val != '0) ? DATA : IDLE;
      DATA:  if (xfer && last_byte) state_nx = WRITE;
      WRITE: if (mem_req_ready)     state_nx = (remain_q == LW'(1)) ? IDLE : DATA;
      RUN:   state_nx = RUN;
      ERR:   state_nx = ERR;
      default: state_nx = ERR;
    endcase
  end

  // Shared shift register: holds address bytes, then count bytes, then the data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      ww_q     <= '0;
    end else begin
      if (xfer && state != IDLE) begin
        idx    <= last_byte ? 2'd0 : idx + 2'd1;
        word_q <= asm_word;
      end
      if (xfer && state == ADDR && last_byte) addr_q   <= AW'({asm_word[31:2], 2'b00});
      if (xfer && state == LEN  && last_byte) remain_q <= len_val;
      if (write_done) begin
        addr_q   <= addr_q + AW'(4);
        remain_q <= remain_q - LW'(1);
        ww_q     <= ww_q + LW'(1);
      end
    end
  end

  assign host_ready    = receiving;
  assign mem_req_valid = (state == WRITE);
  assign core_run      = (state == RUN);
  assign err           = (state == ERR);
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = word_q;
  assign mem_req_fcn   = M_XWR;
  assign mem_req_typ   = MT_W;
  assign words_written = ww_q;

endmodule
